// File: rtl/sigcol_pkg.sv
// sigcol_pkg: shared constants and state encoding for the response signature collector.
//   DATA_W     response bus width
//   SIG_W      signature width
//   POLY       MISR feedback polynomial
//   SEED       signature value loaded on start
//   CNT_W      sample counter width
//   NUM_CHUNKS SIG_W-wide chunks that cover DATA_W
package sigcol_pkg;
    localparam int          DATA_W     = 474;
    localparam int          SIG_W      = 32;
    localparam int          CNT_W      = 16;
    localparam logic [31:0] POLY       = 32'h04C11DB7;
    localparam logic [31:0] SEED       = 32'hFFFFFFFF;
    localparam int          NUM_CHUNKS = 15;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SHIFT,
        CHECK,
        DONE
    } state_t;
endpackage

// File: rtl/misr_fold32.sv
// misr_fold32: combinational XOR-fold of the response bus plus one MISR step.
//   sig      current signature
//   y        response bus, folded in SIG_W-bit chunks (top chunk zero-padded)
//   sig_next signature after shifting, polynomial feedback and folding y
module misr_fold32 #(
    parameter int               DATA_W = sigcol_pkg::DATA_W,
    parameter int               SIG_W  = sigcol_pkg::SIG_W,
    parameter logic [SIG_W-1:0] POLY   = sigcol_pkg::POLY
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic [DATA_W-1:0] y,
    output logic [SIG_W-1:0]  sig_next
);
    localparam int NC = (DATA_W + SIG_W - 1) / SIG_W;

    logic [NC*SIG_W-1:0] y_pad;
    logic [SIG_W-1:0]    fold;

    assign y_pad = (NC*SIG_W)'(y);

    always_comb begin
        fold = '0;
        for (int k = 0; k < NC; k++) fold ^= y_pad[k*SIG_W +: SIG_W];
    end

    assign sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
endmodule

// File: rtl/response_signature_collector.sv
// response_signature_collector: compacts valid responses into a MISR signature, shifts it out, compares.
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pulse that begins a collection (ignored while busy)
//   num_samples    samples to fold, latched on start (0 acts as 1)
//   y, y_valid     response bus and its qualifier (only used in COLLECT)
//   expected_sig   reference signature, sampled in CHECK
//   busy           high in COLLECT, SHIFT and CHECK
//   sig_out(_valid) serial signature, MSB first
//   done, match    result flags, held until the next start
//   signature      live MISR register
//   sample_count   samples folded so far
module response_signature_collector #(
    parameter int               DATA_W = sigcol_pkg::DATA_W,
    parameter int               SIG_W  = sigcol_pkg::SIG_W,
    parameter logic [SIG_W-1:0] POLY   = sigcol_pkg::POLY,
    parameter logic [SIG_W-1:0] SEED   = sigcol_pkg::SEED,
    parameter int               CNT_W  = sigcol_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [DATA_W-1:0] y,
    input  logic              y_valid,
    input  logic [SIG_W-1:0]  expected_sig,
    output logic              busy,
    output logic              sig_out,
    output logic              sig_out_valid,
    output logic              done,
    output logic              match,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  sample_count
);
    import sigcol_pkg::*;

    localparam int IW = $clog2(SIG_W);

    state_t           state, state_next;
    logic [CNT_W-1:0] target;
    logic [IW-1:0]    shift_idx;
    logic [SIG_W-1:0] sig_next;
    logic [CNT_W:0]   count_inc;
    logic             last;

    misr_fold32 #(.DATA_W(DATA_W), .SIG_W(SIG_W), .POLY(POLY)) u_fold (
        .sig      (signature),
        .y        (y),
        .sig_next (sig_next)
    );

    // Widened by one bit so the terminal compare cannot wrap.
    assign count_inc = {1'b0, sample_count} + (CNT_W+1)'(1);
    assign last      = count_inc >= {1'b0, target};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? COLLECT : state;
            COLLECT:    state_next = (y_valid && last) ? SHIFT : COLLECT;
            SHIFT:      state_next = (shift_idx == IW'(SIG_W-1)) ? CHECK : SHIFT;
            CHECK:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature     <= '0;
            sample_count  <= '0;
            target        <= '0;
            shift_idx     <= '0;
            busy          <= 1'b0;
            sig_out       <= 1'b0;
            sig_out_valid <= 1'b0;
            done          <= 1'b0;
            match         <= 1'b0;
        end else begin
            busy <= (state_next == COLLECT) || (state_next == SHIFT) || (state_next == CHECK);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        signature    <= SEED;
                        sample_count <= '0;
                        target       <= (num_samples == '0) ? CNT_W'(1) : num_samples;
                        done         <= 1'b0;
                        match        <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (y_valid) begin
                        signature    <= sig_next;
                        sample_count <= (sample_count == '1) ? sample_count : count_inc[CNT_W-1:0];
                        // Present the MSB of the final signature immediately after the last fold.
                        if (last) begin
                            shift_idx     <= '0;
                            sig_out       <= sig_next[SIG_W-1];
                            sig_out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (shift_idx == IW'(SIG_W-1)) begin
                        sig_out       <= 1'b0;
                        sig_out_valid <= 1'b0;
                    end else begin
                        shift_idx <= shift_idx + IW'(1);
                        sig_out   <= signature[IW'(SIG_W-2) - shift_idx];
                    end
                end
                CHECK: begin
                    match <= (signature == expected_sig);
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_response_signature_collector.sv
// tb_response_signature_collector: directed, table-driven checks of the signature collector.
module tb_response_signature_collector;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef struct {
        bit           sel;
        logic [15:0]  n;
        logic [473:0] y;
        logic [31:0]  exp_in;
        logic [31:0]  sig;
        bit           m;
    } rec_t;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         start = 0;
    logic [15:0]  num_samples = 0;
    logic [473:0] y = '0;
    logic         y_valid = 0;
    logic [31:0]  expected_sig = '0;

    logic         busy_w[2], so_w[2], sov_w[2], done_w[2], match_w[2];
    logic [31:0]  sig_w[2];
    logic [15:0]  cnt_w[2];

    int checks = 0;
    int errors = 0;

    logic [473:0] stim[22];
    rec_t         tbl[7];
    logic [31:0]  got_ser, ref_sig;
    int           got_bits, got_lat;

    always #5 clk = ~clk;

    response_signature_collector #(.SEED(32'h0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .y(y), .y_valid(y_valid), .expected_sig(expected_sig),
        .busy(busy_w[0]), .sig_out(so_w[0]), .sig_out_valid(sov_w[0]),
        .done(done_w[0]), .match(match_w[0]), .signature(sig_w[0]), .sample_count(cnt_w[0])
    );

    response_signature_collector dut_d (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .y(y), .y_valid(y_valid), .expected_sig(expected_sig),
        .busy(busy_w[1]), .sig_out(so_w[1]), .sig_out_valid(sov_w[1]),
        .done(done_w[1]), .match(match_w[1]), .signature(sig_w[1]), .sample_count(cnt_w[1])
    );

    function automatic logic [31:0] fold_m(input logic [473:0] v);
        logic [31:0] f = '0;
        for (int i = 0; i < 474; i++) f[i % 32] = f[i % 32] ^ v[i];
        return f;
    endfunction

    function automatic logic [31:0] misr_m(input logic [31:0] s, input logic [473:0] v);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ fold_m(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Starts a collection over stim[0..nvec-1], then watches the serial phase until done.
    task automatic run(input bit sel, input logic [15:0] n, input int nvec, input bit gaps,
                       input int start_at, input int abort_at, input logic [31:0] exp_in);
        expected_sig = exp_in;
        @(negedge clk);
        start = 1;
        num_samples = n;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < nvec; i++) begin
            if (gaps && (i % 2 == 1)) begin
                y_valid = 0;
                y = ~stim[i];
                start = 1;
                @(negedge clk);
                start = 0;
            end
            y = stim[i];
            y_valid = 1;
            @(negedge clk);
        end
        y_valid = 0;
        y = '0;
        got_ser = '0;
        got_bits = 0;
        got_lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (c == abort_at) return;
            start = (c == start_at);
            y_valid = (c == start_at);
            y = (c == start_at) ? '1 : '0;
            if (sov_w[sel]) begin
                got_ser = {got_ser[30:0], so_w[sel]};
                got_bits++;
            end
            if (done_w[sel]) begin
                got_lat = c;
                break;
            end
            @(negedge clk);
        end
        start = 0;
        y_valid = 0;
        y = '0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 16'd1, 474'h1,         32'h00000001, 32'h00000001, 1'b1};
        tbl[1] = '{1'b1, 16'd1, 474'h0,         32'h00000000, 32'hFB3EE249, 1'b0};
        tbl[2] = '{1'b0, 16'd1, 474'h1 << 473,  32'h02000000, 32'h02000000, 1'b1};
        tbl[3] = '{1'b0, 16'd1, 474'h1 << 32,   32'h00000000, 32'h00000001, 1'b0};
        tbl[4] = '{1'b1, 16'd0, 474'h0,         32'hFB3EE249, 32'hFB3EE249, 1'b1};
        tbl[5] = '{1'b0, 16'd1, {474{1'b1}},    32'h03FFFFFF, 32'h03FFFFFF, 1'b1};
        tbl[6] = '{1'b1, 16'd1, 474'h1,         32'hFB3EE248, 32'hFB3EE248, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_sig",   {32'h0, sig_w[1]}, 64'h0);
        chk("rst_cnt",   64'(cnt_w[1]), 64'h0);
        chk("rst_flags", {59'h0, busy_w[1], so_w[1], sov_w[1], done_w[1], match_w[1]}, 64'h0);
        rst_n = 1;

        for (int r = 0; r < 7; r++) begin
            stim[0] = tbl[r].y;
            run(tbl[r].sel, tbl[r].n, 1, 0, -1, -1, tbl[r].exp_in);
            chk($sformatf("t%0d_sig", r),   64'(sig_w[tbl[r].sel]), 64'(tbl[r].sig));
            chk($sformatf("t%0d_ser", r),   64'(got_ser), 64'(tbl[r].sig));
            chk($sformatf("t%0d_bits", r),  64'(got_bits), 64'd32);
            chk($sformatf("t%0d_lat", r),   64'(got_lat), 64'd33);
            chk($sformatf("t%0d_match", r), 64'(match_w[tbl[r].sel]), 64'(tbl[r].m));
            chk($sformatf("t%0d_cnt", r),   64'(cnt_w[tbl[r].sel]), 64'd1);
        end

        // 22-vector stream, back-to-back then with gaps and a stray start in COLLECT.
        stim[0] = '0;
        for (int k = 1; k < 22; k++) stim[k] = 474'({15{32'(k) * 32'h9E3779B9}}) << k;
        ref_sig = 32'hFFFFFFFF;
        for (int k = 0; k < 22; k++) ref_sig = misr_m(ref_sig, stim[k]);
        for (int g = 0; g < 2; g++) begin
            run(1, 16'd22, 22, g[0], -1, -1, ref_sig);
            chk($sformatf("s22_sig_g%0d", g),   64'(sig_w[1]), 64'(ref_sig));
            chk($sformatf("s22_ser_g%0d", g),   64'(got_ser), 64'(ref_sig));
            chk($sformatf("s22_cnt_g%0d", g),   64'(cnt_w[1]), 64'd22);
            chk($sformatf("s22_match_g%0d", g), 64'(match_w[1]), 64'd1);
            chk($sformatf("s22_lat_g%0d", g),   64'(got_lat), 64'd33);
        end

        // num_samples=0 with start and y_valid pulsed during SHIFT.
        stim[0] = '0;
        run(1, 16'd0, 1, 0, 5, -1, 32'hFB3EE249);
        chk("ss_sig",   64'(sig_w[1]), 64'hFB3EE249);
        chk("ss_ser",   64'(got_ser), 64'hFB3EE249);
        chk("ss_lat",   64'(got_lat), 64'd33);
        chk("ss_cnt",   64'(cnt_w[1]), 64'd1);
        chk("ss_match", 64'(match_w[1]), 64'd1);

        // Asynchronous reset during SHIFT bit 10, then rerun scenario 1.
        stim[0] = 474'h1;
        run(0, 16'd1, 1, 0, -1, 10, 32'h1);
        chk("ab_busy_pre", 64'(busy_w[0]), 64'd1);
        rst_n = 0;
        #1;
        chk("ab_sig",   64'(sig_w[0]), 64'h0);
        chk("ab_cnt",   64'(cnt_w[0]), 64'h0);
        chk("ab_flags", {59'h0, busy_w[0], so_w[0], sov_w[0], done_w[0], match_w[0]}, 64'h0);
        @(negedge clk);
        rst_n = 1;
        run(0, 16'd1, 1, 0, -1, -1, 32'h1);
        chk("ab_re_sig",   64'(sig_w[0]), 64'h1);
        chk("ab_re_ser",   64'(got_ser), 64'h1);
        chk("ab_re_lat",   64'(got_lat), 64'd33);
        chk("ab_re_match", 64'(match_w[0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/response_signature_collector.md
Name: response_signature_collector

Overview:
- Synthesizable consumer of the 474-bit DUT response bus `y`, which the stimulus side currently only prints each posedge.
- Compacts each valid response into a 32-bit MISR signature over a programmed number of samples.
- Serially shifts the final signature out MSB-first, then flags pass/fail against an expected signature.
- Sits at the DUT output, alongside the stimulus driver, so equivalence runs compare one signature instead of full strobe logs.

Parameters:
- DATA_W, 474, response bus width (matches `y`).
- SIG_W, 32, signature width.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SEED, 32'hFFFFFFFF, signature value loaded on start.
- CNT_W, 16, width of the sample counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new collection.
- num_samples  input  CNT_W  samples to fold; latched on start; 0 is treated as 1.
- y  input  DATA_W  DUT response.
- y_valid  input  1  `y` is sampled on this edge.
- expected_sig  input  SIG_W  reference signature; sampled in CHECK.
- busy  output  1  high in COLLECT, SHIFT and CHECK.
- sig_out  output  1  serial signature bit.
- sig_out_valid  output  1  `sig_out` is meaningful.
- done  output  1  result valid; held until the next start.
- match  output  1  signature equals `expected_sig`; valid only when `done`.
- signature  output  SIG_W  current MISR contents.
- sample_count  output  CNT_W  samples folded so far.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - signature=0, sample_count=0.
  - busy, sig_out, sig_out_valid, done, match all 0.
- Fold function:
  - Split `y` into 15 chunks of SIG_W bits; chunk k = y[32k+31:32k].
  - Chunk 14 holds bits 473:448 and is zero-padded above bit 25.
  - fold = XOR of all 15 chunks (combinational).
- MISR update: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(y).
- States: IDLE, COLLECT, SHIFT, CHECK, DONE.
  - IDLE: start -> COLLECT; on the same edge, signature<=SEED, sample_count<=0, target<=max(num_samples,1), done<=0.
  - COLLECT:
    - Each edge with y_valid: signature<=sig_next, sample_count++.
    - When the increment reaches target -> SHIFT (the last sample is folded on that edge).
    - y_valid low: hold.
  - SHIFT:
    - SIG_W cycles; sig_out=signature[31-i] on cycle i, sig_out_valid=1.
    - The signature register is unchanged; a separate shift index counts 0..31.
    - After i=31 -> CHECK.
  - CHECK: one cycle; match<=(signature==expected_sig), done<=1 -> DONE.
  - DONE: done and match hold; start -> COLLECT with the same reinit as from IDLE.
- Latency from start:
  - Nth y_valid folds on edge N after start (if back-to-back).
  - First serial bit appears the cycle after the last fold.
  - done rises SIG_W+1 cycles after the last fold.
- Boundary conditions:
  - start during COLLECT, SHIFT or CHECK is ignored.
  - y_valid outside COLLECT is ignored.
  - sample_count saturates at the max value (it cannot exceed target).
  - rst_n low mid-operation aborts immediately to reset values; no partial output.
  - Outputs are registered, except `signature` and `sample_count`, which expose their registers directly.

Decomposition:
- Shared package `sigcol_pkg`: state enum, DATA_W/SIG_W/POLY/SEED constants, NUM_CHUNKS=15.
- One natural sub-module, `misr_fold32`:
  - Purely combinational fold plus MISR step.
  - Inputs: sig, y. Output: sig_next.
- The collector instantiates `misr_fold32` once.

Test Plan:
1. SEED=0, num_samples=1, y=474'h1 -> signature=32'h00000001; sig_out is 31 zeros then 1; expected_sig=1 -> done=1, match=1.
2. Default SEED, num_samples=1, y=0 -> signature=32'hFB3EE249; expected_sig=32'h0 -> match=0.
3. SEED=0, num_samples=1, y with only bit 473 set -> signature=32'h02000000; only bit 32 set -> 32'h00000001 (folds onto bit 0, same as bit 0).
4. Replay the 22 bench vectors (initial zero plus 21 pattern vectors) through a reference DUT model with num_samples=22.
   - Gaps in y_valid must not change the result versus back-to-back delivery.
   - sample_count=22 when done rises.
5. num_samples=0 -> behaves as 1; start asserted during SHIFT -> ignored, done still rises after 32 serial bits.
6. rst_n pulsed low at SHIFT bit 10 -> all outputs 0 immediately, state IDLE; a subsequent start with the scenario-1 stimulus reproduces the scenario-1 result.
